move_arbiter: RTL and testbench

MOVE_ARBITER -- requirements
Module: move_arbiter

---
 rtl/game_pkg.sv | 36 +++
 rtl/btn_sync.sv | 22 ++
 rtl/move_arbiter.sv | 117 +++++++++++
 tb/tb_move_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types: move directions and the move arbiter state encoding.
package game_pkg;

    // Move code offered to the movement/rng consumer.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    // Move arbiter control states.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        WAIT_ACK     = 2'd2,
        WAIT_RELEASE = 2'd3
    } arb_state_t;

    // Width of the debounce/release qualification counter.
    localparam int CNT_W = 20;

    // Fixed-priority pick over {right, left, bot, top}: top wins, right loses.
    function automatic dir_t pick_dir(input logic [3:0] btns);
        if (btns[0]) begin
            return UP;
        end else if (btns[1]) begin
            return DOWN;
        end else if (btns[2]) begin
            return LEFT;
        end else begin
            return RIGHT;
        end
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the four raw pushbuttons.
module btn_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    // First flop may go metastable; second flop hands a settled value onward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/move_arbiter.sv
// Turns four raw pushbuttons into debounced, one-per-press move codes
// offered on a valid/ack handshake, and counts accepted moves.
module move_arbiter
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_top,
    input  logic        btn_bot,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        enable,
    input  logic        busy,
    input  logic        dir_ack,
    output logic        dir_valid,
    output dir_t        dir,
    output logic [15:0] move_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [3:0]       btn_s;
    arb_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    dir_t             cand, cand_nx;
    logic             dir_valid_nx;
    dir_t             dir_nx;
    logic [15:0]      move_count_nx;

    // Bit order matches the direction codes, so a button index is its dir_t.
    btn_sync u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   ({btn_right, btn_left, btn_bot, btn_top}),
        .q   (btn_s)
    );

    // Saturating increment: the counter must never wrap back to zero.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // Next-state and next-output decode for the arbiter FSM.
    always_comb begin
        // NOTE: every target gets a hold value first, so no path can infer a latch.
        state_nx      = state;
        cnt_nx        = cnt;
        cand_nx       = cand;
        dir_valid_nx  = dir_valid;
        dir_nx        = dir;
        move_count_nx = move_count;
        case (state)
            IDLE: begin
                if (enable && !busy && (|btn_s)) begin
                    cand_nx  = pick_dir(btn_s);
                    cnt_nx   = '0;
                    state_nx = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!btn_s[cand] || !enable) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    dir_valid_nx = 1'b1;
                    dir_nx       = cand;
                    state_nx     = WAIT_ACK;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            WAIT_ACK: begin
                // Offer is held regardless of enable, busy or buttons.
                if (dir_ack) begin
                    dir_valid_nx  = 1'b0;
                    move_count_nx = move_count + 16'd1;
                    cnt_nx        = '0;
                    state_nx      = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                // All buttons must stay low for the full window; any press restarts it.
                if (|btn_s) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset drops any pending move.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cand       <= UP;
            dir_valid  <= 1'b0;
            dir        <= UP;
            move_count <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state      <= state_nx;
            cnt        <= cnt_nx;
            cand       <= cand_nx;
            dir_valid  <= dir_valid_nx;
            dir        <= dir_nx;
            move_count <= move_count_nx;
        end
    end

endmodule

// File: tb/tb_move_arbiter.sv
// Randomized and directed bench for move_arbiter with a scoreboard monitor.
module tb_move_arbiter;
    import game_pkg::*;

    localparam int unsigned D      = 4;
    localparam int unsigned SETTLE = 2 * D + 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_top = 1'b0, btn_bot = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        enable = 1'b0, busy = 1'b0, dir_ack = 1'b0;
    logic        dir_valid;
    dir_t        dir;
    logic [15:0] move_count;

    typedef struct {
        logic [1:0]  code;
        int unsigned earliest;
        int unsigned latest;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur_exp;
    logic [1:0]  held_dir = 2'd0;
    logic        prev_valid = 1'b0;
    logic [15:0] exp_count = 16'd0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    move_arbiter #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_top    (btn_top),
        .btn_bot    (btn_bot),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .enable     (enable),
        .busy       (busy),
        .dir_ack    (dir_ack),
        .dir_valid  (dir_valid),
        .dir        (dir),
        .move_count (move_count)
    );

    always #10 clk = ~clk;

    // Rising-edge counter used as the time base for latency expectations.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    task automatic check_range(input string name, input int unsigned actual,
                               input int unsigned lo, input int unsigned hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Reference priority: lowest set index (top=0, bot=1, left=2, right=3) wins.
    function automatic logic [1:0] prio(input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic set_btns(input logic [3:0] m);
        btn_top   = m[0];
        btn_bot   = m[1];
        btn_left  = m[2];
        btn_right = m[3];
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_move(input logic [1:0] code, input int unsigned lo, input int unsigned hi);
        exp_t e;
        e.code     = code;
        e.earliest = lo;
        e.latest   = hi;
        exp_q.push_back(e);
    endtask

    // Bounded wait for an offer; an expired bound is a failed comparison.
    task automatic wait_valid();
        for (int i = 0; i < 64 && !dir_valid; i++) tick(1);
        check("move_offered", 32'(dir_valid), 32'd1);
    endtask

    // One-cycle acknowledge; the offer must drop next cycle and count once.
    task automatic ack_move();
        dir_ack = 1'b1;
        tick(1);
        dir_ack = 1'b0;
        exp_count = exp_count + 16'd1;
        check("valid_after_ack", 32'(dir_valid), 32'd0);
        check("move_count", 32'(move_count), 32'(exp_count));
    endtask

    task automatic release_all();
        set_btns(4'b0000);
        tick(SETTLE);
    endtask

    // Monitor: pops the scoreboard on every new offer and checks the held code.
    always @(negedge clk) begin
        if (dir_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_move actual=dir %0d at cycle %0d required=no move", dir, cyc);
            end else begin
                cur_exp = exp_q.pop_front();
                held_dir = cur_exp.code;
                check("move_dir", 32'(dir), 32'(cur_exp.code));
                check_range("move_cycle", cyc, cur_exp.earliest, cur_exp.latest);
            end
        end else if (dir_valid && prev_valid && dir !== held_dir) begin
            check("dir_hold", 32'(dir), 32'(held_dir));
        end
        prev_valid = dir_valid;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned p, e, b, r;
        logic [3:0]  mask;

        // Reset state
        tick(3);
        check("rst_valid", 32'(dir_valid), 32'd0);
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_count", 32'(move_count), 32'd0);
        rst    = 1'b1;
        enable = 1'b1;
        tick(3);

        // Ack with nothing offered is ignored
        dir_ack = 1'b1;
        tick(1);
        dir_ack = 1'b0;
        check("ack_idle_count", 32'(move_count), 32'd0);
        check("ack_idle_valid", 32'(dir_valid), 32'd0);

        // Held left: exact latency, then offer survives enable/busy/button churn
        p = cyc;
        set_btns(4'b0100);
        expect_move(2'(LEFT), p + D + 3, p + D + 3);
        tick(D + 2);
        check("latency_early", 32'(dir_valid), 32'd0);
        tick(1);
        check("latency_on", 32'(dir_valid), 32'd1);
        enable = 1'b0;
        busy   = 1'b1;
        set_btns(4'b0101);
        tick(10);
        enable = 1'b1;
        busy   = 1'b0;
        tick(p + 50 - cyc);
        check("held_valid_50", 32'(dir_valid), 32'd1);
        check("held_dir_50", 32'(dir), 32'(LEFT));
        ack_move();
        release_all();

        // Top and right together: top wins; held right yields no repeat
        p = cyc;
        set_btns(4'b1001);
        expect_move(2'(UP), p + D + 3, p + D + 3);
        wait_valid();
        ack_move();
        set_btns(4'b1000);
        tick(20);
        check("no_repeat_held", 32'(dir_valid), 32'd0);
        release_all();
        check("no_repeat_released", 32'(dir_valid), 32'd0);
        p = cyc;
        set_btns(4'b1000);
        expect_move(2'(RIGHT), p + D + 3, p + D + 3);
        wait_valid();
        ack_move();
        release_all();

        // Short bot glitch is rejected
        set_btns(4'b0010);
        tick(3);
        release_all();
        check("glitch_valid", 32'(dir_valid), 32'd0);

        // Busy holds off a pressed button until it clears
        busy = 1'b1;
        set_btns(4'b0010);
        tick(20);
        check("busy_block", 32'(dir_valid), 32'd0);
        b = cyc;
        busy = 1'b0;
        expect_move(2'(DOWN), b + D + 1, b + D + 3);
        wait_valid();
        ack_move();
        release_all();

        // Enable dropped during debounce aborts and restarts qualification
        p = cyc;
        set_btns(4'b0001);
        tick(4);
        e = cyc;
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        expect_move(2'(UP), e + D + 2, e + D + 3);
        wait_valid();
        ack_move();
        release_all();

        // Randomized presses, glitches and late extra buttons
        for (int n = 0; n < 30; n++) begin
            mask = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) begin
                set_btns(mask);
                tick($urandom_range(1, D - 1));
                release_all();
            end else begin
                p = cyc;
                set_btns(mask);
                expect_move(prio(mask), p + D + 3, p + D + 3);
                if ($urandom_range(0, 1) == 1) begin
                    tick($urandom_range(1, D + 2));
                    set_btns(mask | 4'($urandom_range(0, 15)));
                end
                wait_valid();
                tick($urandom_range(0, 4));
                ack_move();
                release_all();
            end
        end

        // Counter wrap: preload 65535 while an offer is pending
        p = cyc;
        set_btns(4'b1000);
        expect_move(2'(RIGHT), p + D + 3, p + D + 3);
        wait_valid();
        force dut.move_count = 16'hFFFF;
        tick(1);
        release dut.move_count;
        check("preload", 32'(move_count), 32'hFFFF);
        exp_count = 16'hFFFF;
        ack_move();
        release_all();

        // Reset while an offer is pending drops it at once; held button re-qualifies
        p = cyc;
        set_btns(4'b0001);
        expect_move(2'(UP), p + D + 3, p + D + 3);
        wait_valid();
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_valid", 32'(dir_valid), 32'd0);
        check("rst_async_count", 32'(move_count), 32'd0);
        exp_count = 16'd0;
        tick(3);
        r = cyc;
        rst = 1'b1;
        expect_move(2'(UP), r + D + 3, r + D + 3);
        wait_valid();
        ack_move();
        release_all();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
